iic_bus_monitor: RTL
====================

// Module: iic_bus_monitor
// PURPOSE
//  Passive I2C bus monitor on the filtered clean side of the I2C glitch filter.
//  - Consumes Scl_clean/Sda_clean and decodes START, repeated START and STOP.
//  - Reports address/data bytes and the ACK bit on single-cycle strobes.
//  - Tracks bus-busy and flags framing errors; feeds the slow-control logger
//    and the debug header.
// PARAMETERS
//  TIMEOUT_CYCLES  3125000  SCL-low cycles before timeout (25 ms @ 125 MHz)
//  TO_W            22       timeout counter width; must hold TIMEOUT_CYCLES
//  CNT_W           8        byte counter width, saturating
// PORTS
//  Sysclk        in   1      system clock, 125 MHz
//  Rst_n         in   1      asynchronous reset, active-low
//  Scl_clean     in   1      filtered SCL, Sysclk-synchronous
//  Sda_clean     in   1      filtered SDA, Sysclk-synchronous
//  Start_det     out  1      1-cycle pulse on START or repeated START
//  Stop_det      out  1      1-cycle pulse on STOP
//  Bus_busy      out  1      high from START until STOP/timeout
//  Byte_valid    out  1      1-cycle pulse: Byte_data valid
//  Byte_data     out  8      last received byte, MSB first on wire
//  Byte_is_addr  out  1      Byte_data is first byte after (re)START
//  Ack_valid     out  1      1-cycle pulse on 9th SCL rise
//  Ack           out  1      1 = ACK (SDA low on 9th bit), 0 = NACK
//  Byte_cnt      out  CNT_W  bytes since last START, saturates at all-ones
//  Frame_err     out  1      1-cycle pulse: START/STOP with bit count not 0
//  Timeout       out  1      1-cycle pulse on SCL-stuck-low timeout
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, bit count 0, sample regs = 1 (bus idle).
//  - Inputs registered once (scl_q, sda_q); edges = current vs. _q.
//  - START: SDA 1->0 while SCL==1 and scl_q==1. STOP: SDA 0->1, same condition.
//  - SDA and SCL changing in the same cycle: no START/STOP; an SCL rise
//    samples the current SDA.
//  - Data bits are sampled on SCL rise only; SCL fall only advances the state.
//  - States:
//      IDLE -START-> ADDR
//      ADDR/DATA: shift bit; on 8th bit -> ACK
//      ACK: on SCL rise, pulse Ack_valid -> DATA
//      Any state: STOP -> IDLE; START -> ADDR
//  - Byte_valid/Byte_data/Byte_is_addr are registered the cycle after the 8th
//    SCL rise (latency 1). Ack_valid is 1 cycle after the 9th rise.
//  - Byte_cnt: cleared on START; +1 at each Byte_valid; holds at max.
//  - Bus_busy: set with Start_det; cleared with Stop_det or Timeout.
//  - Frame_err: START or STOP seen with bit count in 1..8 (mid-byte). The
//    START/STOP still takes effect. The partial byte is dropped; no Byte_valid.
//  - STOP in IDLE: Stop_det pulses, no Frame_err.
//  - Asserting Rst_n low mid-transfer returns everything to reset values at
//    once. After release, the block waits for a fresh START; bits before it
//    are ignored.
// CONFIGURATION
//  IIC_MON_TIMEOUT_EN defined:
//   - TO_W counter counts cycles with Bus_busy=1 and SCL==0; clears on SCL==1.
//   - On reaching TIMEOUT_CYCLES-1: pulse Timeout, force IDLE, clear Bus_busy.
//   - Counter then holds until SCL==1.
//  Undefined: no counter; Timeout tied 0; TIMEOUT_CYCLES/TO_W unused.
// STRUCTURE
//  - Package iic_mon_pkg: state encoding (IDLE, ADDR, DATA, ACK), BIT_CNT_W=4,
//    default TIMEOUT_CYCLES.
//  - Sub-module iic_edge_det: register plus rise/fall pulse for one line;
//    instantiated twice (SCL, SDA).
//  - All else in one FSM plus datapath always block.
// TESTING
//  1. Reset: Rst_n=0 with random lines -> all outputs 0; release, SCL=SDA=1
//     -> no pulses.
//  2. START, addr 0xA1, ACK, data 0x5C, NACK, STOP ->
//     - Start_det, Byte_valid(0xA1, addr=1), Ack_valid(Ack=1)
//     - Byte_valid(0x5C, addr=0), Ack_valid(Ack=0), Stop_det
//     - Byte_cnt=2; Bus_busy low after STOP.
//  3. START, 0x90, ACK, repeated START, 0x91 -> second Start_det; Byte_cnt
//     back to 1; Byte_is_addr=1 for 0x91; Bus_busy stays 1.
//  4. STOP after 3 bits -> Frame_err and Stop_det same cycle; no Byte_valid;
//     state IDLE.
//  5. SDA and SCL toggle in same cycle while SCL high -> no Start_det/Stop_det.
//  6. With IIC_MON_TIMEOUT_EN and TIMEOUT_CYCLES=100, SCL held low after
//     START -> Timeout exactly 100 cycles after SCL fall; Bus_busy 0.
//     Without the macro, Timeout never asserts.

Source files
------------

// File: rtl/iic_mon_pkg.sv
// Shared state encoding and default sizing for the passive I2C bus monitor.
package iic_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    ACK  = 2'd3
  } iic_state_e;

  localparam int BIT_CNT_W          = 4;
  localparam int TIMEOUT_CYCLES_DEF = 3125000;
  localparam int TO_W_DEF           = 22;

endpackage

// File: rtl/iic_edge_det.sv
// One-line sampler: registers the line and flags rise/fall against that register.
module iic_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic rise_o,
  output logic fall_o
);

  logic line_q;
  logic line_d;

  always_comb begin
    line_d = line_i;
  end

  // Resets high so an idle bus produces no edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= 1'b1;
    end else begin
      line_q <= line_d;
    end
  end

  assign rise_o = line_i & ~line_q;
  assign fall_o = ~line_i & line_q;

endmodule

// File: rtl/iic_bus_monitor.sv
// Passive I2C monitor: START/STOP decode, byte/ACK strobes, busy and framing flags.
// Optional SCL-stuck-low timeout is built when IIC_MON_TIMEOUT_EN is defined.
module iic_bus_monitor
  import iic_mon_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TO_W           = TO_W_DEF,
  parameter int CNT_W          = 8
) (
  input  logic             Sysclk,
  input  logic             Rst_n,
  input  logic             Scl_clean,
  input  logic             Sda_clean,
  output logic             Start_det,
  output logic             Stop_det,
  output logic             Bus_busy,
  output logic             Byte_valid,
  output logic [7:0]       Byte_data,
  output logic             Byte_is_addr,
  output logic             Ack_valid,
  output logic             Ack,
  output logic [CNT_W-1:0] Byte_cnt,
  output logic             Frame_err,
  output logic             Timeout
);

  localparam int LN_SCL = 0;
  localparam int LN_SDA = 1;

  logic [1:0] lines_in;
  logic [1:0] line_rise;
  logic [1:0] line_fall;

  assign lines_in = {Sda_clean, Scl_clean};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_edge
      iic_edge_det u_edge (
        .clk    (Sysclk),
        .rst_n  (Rst_n),
        .line_i (lines_in[gi]),
        .rise_o (line_rise[gi]),
        .fall_o (line_fall[gi])
      );
    end
  endgenerate

  logic scl_rise, scl_fall, scl_steady_hi;
  logic start_cond, stop_cond;

  assign scl_rise      = line_rise[LN_SCL];
  assign scl_fall      = line_fall[LN_SCL];
  // SDA edges only count as START/STOP when SCL was high in both samples.
  assign scl_steady_hi = Scl_clean & ~scl_rise;
  assign start_cond    = line_fall[LN_SDA] & scl_steady_hi;
  assign stop_cond     = line_rise[LN_SDA] & scl_steady_hi;

  iic_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 bit_pend_q, bit_pend_d;
  logic [6:0]           shift_q, shift_d;
  logic                 start_det_q, start_det_d;
  logic                 stop_det_q, stop_det_d;
  logic                 bus_busy_q, bus_busy_d;
  logic                 byte_valid_q, byte_valid_d;
  logic [7:0]           byte_data_q, byte_data_d;
  logic                 byte_is_addr_q, byte_is_addr_d;
  logic                 ack_valid_q, ack_valid_d;
  logic                 ack_q, ack_d;
  logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic                 frame_err_q, frame_err_d;
  logic                 timeout_q, timeout_d;
  logic                 timeout_hit;

`ifdef IIC_MON_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Holds at TO_LAST after firing; busy is gone so it cannot fire again.
  always_comb begin
    to_cnt_d    = to_cnt_q;
    timeout_hit = 1'b0;
    if (Scl_clean) begin
      to_cnt_d = '0;
    end else if (bus_busy_q) begin
      if (to_cnt_q == TO_LAST) begin
        timeout_hit = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge Sysclk or negedge Rst_n) begin
    if (!Rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  // No timeout logic; the parameters are still referenced so both builds share one interface.
  assign timeout_hit = 1'b0 & (TO_W > 0) & (TIMEOUT_CYCLES > 0);
`endif

  // A bit is counted once its SCL high period ends, so the rise that precedes
  // a STOP or repeated START is not mistaken for a partial byte.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    bit_pend_d     = bit_pend_q;
    shift_d        = shift_q;
    start_det_d    = 1'b0;
    stop_det_d     = 1'b0;
    bus_busy_d     = bus_busy_q;
    byte_valid_d   = 1'b0;
    byte_data_d    = byte_data_q;
    byte_is_addr_d = byte_is_addr_q;
    ack_valid_d    = 1'b0;
    ack_d          = ack_q;
    byte_cnt_d     = byte_cnt_q;
    frame_err_d    = 1'b0;
    timeout_d      = timeout_hit;

    if (start_cond) begin
      start_det_d = 1'b1;
      frame_err_d = (bit_cnt_q != '0);
      state_d     = ADDR;
      bit_cnt_d   = '0;
      bit_pend_d  = 1'b0;
      shift_d     = '0;
      byte_cnt_d  = '0;
      bus_busy_d  = 1'b1;
    end else if (stop_cond) begin
      stop_det_d  = 1'b1;
      frame_err_d = (bit_cnt_q != '0);
      state_d     = IDLE;
      bit_cnt_d   = '0;
      bit_pend_d  = 1'b0;
      bus_busy_d  = 1'b0;
    end else if (timeout_hit) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      bit_pend_d = 1'b0;
      bus_busy_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[5:0], Sda_clean};
            if (bit_cnt_q == BIT_CNT_W'(7)) begin
              byte_valid_d   = 1'b1;
              byte_data_d    = {shift_q, Sda_clean};
              byte_is_addr_d = (state_q == ADDR);
              if (byte_cnt_q != {CNT_W{1'b1}}) begin
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
              end
              state_d    = ACK;
              bit_cnt_d  = BIT_CNT_W'(8);
              bit_pend_d = 1'b0;
            end else begin
              bit_pend_d = 1'b1;
            end
          end else if (scl_fall && bit_pend_q) begin
            bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
            bit_pend_d = 1'b0;
          end
        end
        ACK: begin
          if (scl_rise) begin
            ack_valid_d = 1'b1;
            ack_d       = ~Sda_clean;
            state_d     = DATA;
            bit_cnt_d   = '0;
            bit_pend_d  = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge Sysclk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      bit_pend_q     <= 1'b0;
      shift_q        <= '0;
      start_det_q    <= 1'b0;
      stop_det_q     <= 1'b0;
      bus_busy_q     <= 1'b0;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= '0;
      byte_is_addr_q <= 1'b0;
      ack_valid_q    <= 1'b0;
      ack_q          <= 1'b0;
      byte_cnt_q     <= '0;
      frame_err_q    <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      bit_pend_q     <= bit_pend_d;
      shift_q        <= shift_d;
      start_det_q    <= start_det_d;
      stop_det_q     <= stop_det_d;
      bus_busy_q     <= bus_busy_d;
      byte_valid_q   <= byte_valid_d;
      byte_data_q    <= byte_data_d;
      byte_is_addr_q <= byte_is_addr_d;
      ack_valid_q    <= ack_valid_d;
      ack_q          <= ack_d;
      byte_cnt_q     <= byte_cnt_d;
      frame_err_q    <= frame_err_d;
      timeout_q      <= timeout_d;
    end
  end

  assign Start_det    = start_det_q;
  assign Stop_det     = stop_det_q;
  assign Bus_busy     = bus_busy_q;
  assign Byte_valid   = byte_valid_q;
  assign Byte_data    = byte_data_q;
  assign Byte_is_addr = byte_is_addr_q;
  assign Ack_valid    = ack_valid_q;
  assign Ack          = ack_q;
  assign Byte_cnt     = byte_cnt_q;
  assign Frame_err    = frame_err_q;
  assign Timeout      = timeout_q;

endmodule
